// File: rtl/mode_control_unit_pkg.sv
// Shared encodings for the front-panel controller: stopwatch/watch state codes,
// button-priority selection and the cursor width helper.
package mode_control_unit_pkg;

  localparam logic [1:0] SW_STOP = 2'd0;
  localparam logic [1:0] SW_RUN  = 2'd1;
  localparam logic [1:0] SW_CLR  = 2'd2;

  localparam logic W_IDLE = 1'b0;
  localparam logic W_EDIT = 1'b1;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_C,
    BTN_L,
    BTN_R,
    BTN_U,
    BTN_D
  } btn_sel_e;

  function automatic int cursor_w(input int num_fields);
    return $clog2(num_fields + 1);
  endfunction

  // Same-cycle presses resolve C > L > R > U > D.
  function automatic btn_sel_e pick_btn(input logic c, input logic l, input logic r,
                                        input logic u, input logic d);
    if (c)      return BTN_C;
    else if (l) return BTN_L;
    else if (r) return BTN_R;
    else if (u) return BTN_U;
    else if (d) return BTN_D;
    else        return BTN_NONE;
  endfunction

endpackage

// File: rtl/mode_control_unit_hold_repeat.sv
// Long-press auto-repeat: one pulse at LONG_PRESS_MS ticks of hold, then one every REPEAT_MS.
// o_pulse is a same-cycle strobe qualified by i_tick; the parent registers it. No backpressure.
module hold_repeat_gen #(
  parameter int LONG_PRESS_MS = 500,
  parameter int REPEAT_MS     = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_en,
  input  logic i_hold,
  output logic o_pulse
);

  localparam int LW = $clog2(LONG_PRESS_MS + 1);
  localparam int RW = $clog2(REPEAT_MS + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_PRESS_MS);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_MS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_MS - 1);

  logic [LW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          active;
  logic          long_done;

  assign active    = i_en & i_hold;
  assign long_done = (hold_cnt == LONG_MAX);
  assign o_pulse   = active & i_tick &
                     ((~long_done & (hold_cnt == LONG_LAST)) | (long_done & (rep_cnt == REP_LAST)));

  // hold_cnt saturates at LONG_PRESS_MS; rep_cnt then paces the repeat period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (!active) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (i_tick) begin
      if (!long_done)             hold_cnt <= hold_cnt + LW'(1);
      else if (rep_cnt == REP_LAST) rep_cnt <= '0;
      else                        rep_cnt  <= rep_cnt + RW'(1);
    end
  end

endmodule

// File: rtl/mode_control_unit.sv
// Front-panel controller: routes buttons by mode, owns stopwatch and watch-edit FSMs.
// All outputs registered, one cycle after the press; presses that are gated off are dropped.
module mode_control_unit
  import mode_control_unit_pkg::*;
#(
  parameter int NUM_FIELDS      = 4,
  parameter int LONG_PRESS_MS   = 500,
  parameter int REPEAT_MS       = 100,
  parameter int EDIT_TIMEOUT_MS = 10000,
  parameter int BLINK_HALF_MS   = 250
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_tick_1ms,
  input  logic                              i_sw_mode,
  input  logic                              i_sw_up_down,
  input  logic                              i_btn_L,
  input  logic                              i_btn_R,
  input  logic                              i_btn_C,
  input  logic                              i_btn_U,
  input  logic                              i_btn_D,
  input  logic                              i_btn_U_hold,
  input  logic                              i_btn_D_hold,
  output logic                              o_sw_run_stop,
  output logic                              o_sw_clear,
  output logic                              o_sw_mode,
  output logic [cursor_w(NUM_FIELDS)-1:0]   o_w_cursor,
  output logic                              o_w_edit,
  output logic                              o_w_blink_on,
  output logic                              o_w_inc,
  output logic                              o_w_dec
);

  localparam int CW = cursor_w(NUM_FIELDS);
  localparam int TW = $clog2(EDIT_TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_HALF_MS + 1);
  localparam logic [CW-1:0] CUR_MAX = CW'(NUM_FIELDS);
  localparam logic [TW-1:0] TO_LAST = TW'(EDIT_TIMEOUT_MS - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF_MS - 1);

  // ---------------- stopwatch ----------------
  logic [1:0] sw_state, sw_next;

  always_comb begin
    sw_next = sw_state;
    case (sw_state)
      SW_STOP: if (i_sw_mode & i_btn_R) sw_next = SW_RUN;
               else if (i_sw_mode & i_btn_L) sw_next = SW_CLR;
      SW_RUN:  if (i_sw_mode & i_btn_R) sw_next = SW_STOP;
      default: sw_next = SW_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_state      <= SW_STOP;
      o_sw_run_stop <= 1'b0;
      o_sw_clear    <= 1'b0;
      o_sw_mode     <= 1'b0;
    end else begin
      sw_state      <= sw_next;
      o_sw_run_stop <= (sw_next == SW_RUN);
      o_sw_clear    <= (sw_next == SW_CLR);
      if (sw_state != SW_RUN) o_sw_mode <= i_sw_up_down;
    end
  end

  // ---------------- watch edit ----------------
  logic          w_state;
  logic [TW-1:0] to_cnt, to_nx;
  logic [BW-1:0] bl_cnt, bl_nx;
  logic [CW-1:0] cursor_nx;
  logic          w_state_nx, blink_nx, inc_nx, dec_nx;
  logic          acted, force_blink, rep_en, rep_u, rep_d;
  btn_sel_e      sel;

  assign sel      = i_sw_mode ? BTN_NONE : pick_btn(i_btn_C, i_btn_L, i_btn_R, i_btn_U, i_btn_D);
  assign rep_en   = (w_state == W_EDIT) & ~i_sw_mode & ~(i_btn_U_hold & i_btn_D_hold);
  assign o_w_edit = (w_state == W_EDIT);

  hold_repeat_gen #(.LONG_PRESS_MS(LONG_PRESS_MS), .REPEAT_MS(REPEAT_MS)) u_rep_u (
    .clk(clk), .reset(reset), .i_tick(i_tick_1ms), .i_en(rep_en),
    .i_hold(i_btn_U_hold), .o_pulse(rep_u)
  );

  hold_repeat_gen #(.LONG_PRESS_MS(LONG_PRESS_MS), .REPEAT_MS(REPEAT_MS)) u_rep_d (
    .clk(clk), .reset(reset), .i_tick(i_tick_1ms), .i_en(rep_en),
    .i_hold(i_btn_D_hold), .o_pulse(rep_d)
  );

  always_comb begin
    w_state_nx  = w_state;
    cursor_nx   = o_w_cursor;
    inc_nx      = 1'b0;
    dec_nx      = 1'b0;
    acted       = 1'b0;
    force_blink = 1'b0;
    to_nx       = to_cnt;
    bl_nx       = bl_cnt;
    blink_nx    = o_w_blink_on;

    if (w_state == W_IDLE) begin
      if (sel == BTN_C) begin
        w_state_nx  = W_EDIT;
        cursor_nx   = CW'(1);
        force_blink = 1'b1;
        acted       = 1'b1;
      end
    end else if (i_sw_mode) begin
      w_state_nx = W_IDLE;
      cursor_nx  = '0;
    end else begin
      acted = 1'b1;
      case (sel)
        BTN_C: begin w_state_nx = W_IDLE; cursor_nx = '0; end
        BTN_L: begin
          cursor_nx   = (o_w_cursor >= CUR_MAX) ? CW'(1) : o_w_cursor + CW'(1);
          force_blink = 1'b1;
        end
        BTN_R: begin
          cursor_nx   = (o_w_cursor <= CW'(1)) ? CUR_MAX : o_w_cursor - CW'(1);
          force_blink = 1'b1;
        end
        BTN_U:   begin inc_nx = 1'b1; force_blink = 1'b1; end
        BTN_D:   begin dec_nx = 1'b1; force_blink = 1'b1; end
        default: acted = 1'b0;
      endcase
      // A commit wins over a repeat landing in the same cycle.
      if (sel != BTN_C && (rep_u || rep_d)) begin
        inc_nx      = inc_nx | rep_u;
        dec_nx      = dec_nx | rep_d;
        acted       = 1'b1;
        force_blink = 1'b1;
      end
      if (!acted && i_tick_1ms) begin
        if (to_cnt >= TO_LAST) begin
          w_state_nx = W_IDLE;
          cursor_nx  = '0;
        end else begin
          to_nx = to_cnt + TW'(1);
        end
      end
    end

    if (acted) to_nx = '0;

    if (w_state_nx == W_IDLE) begin
      to_nx    = '0;
      bl_nx    = '0;
      blink_nx = 1'b1;
    end else if (force_blink) begin
      bl_nx    = '0;
      blink_nx = 1'b1;
    end else if (i_tick_1ms) begin
      if (bl_cnt >= BL_LAST) begin
        bl_nx    = '0;
        blink_nx = ~o_w_blink_on;
      end else begin
        bl_nx = bl_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state      <= W_IDLE;
      o_w_cursor   <= '0;
      o_w_blink_on <= 1'b1;
      o_w_inc      <= 1'b0;
      o_w_dec      <= 1'b0;
      to_cnt       <= '0;
      bl_cnt       <= '0;
    end else begin
      w_state      <= w_state_nx;
      o_w_cursor   <= cursor_nx;
      o_w_blink_on <= blink_nx;
      o_w_inc      <= inc_nx;
      o_w_dec      <= dec_nx;
      to_cnt       <= to_nx;
      bl_cnt       <= bl_nx;
    end
  end

endmodule

// File: tb/tb_mode_control_unit.sv
// Directed-vector bench for mode_control_unit at default parameters, tick strobe held high.
module tb_mode_control_unit;

  logic       clk, reset, tick, sw_mode, up_down;
  logic       btn_L, btn_R, btn_C, btn_U, btn_D, U_hold, D_hold;
  logic       run_stop, sw_clear, sw_mode_o, w_edit, blink_on, w_inc, w_dec;
  logic [2:0] cursor;

  int n_vec = 0;
  int n_bad = 0;

  mode_control_unit dut (
    .clk(clk), .reset(reset), .i_tick_1ms(tick), .i_sw_mode(sw_mode),
    .i_sw_up_down(up_down), .i_btn_L(btn_L), .i_btn_R(btn_R), .i_btn_C(btn_C),
    .i_btn_U(btn_U), .i_btn_D(btn_D), .i_btn_U_hold(U_hold), .i_btn_D_hold(D_hold),
    .o_sw_run_stop(run_stop), .o_sw_clear(sw_clear), .o_sw_mode(sw_mode_o),
    .o_w_cursor(cursor), .o_w_edit(w_edit), .o_w_blink_on(blink_on),
    .o_w_inc(w_inc), .o_w_dec(w_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask = {C, L, R, U, D}; one-cycle pulse, returns at the negedge after the acting edge.
  task automatic press(input logic [4:0] mask);
    {btn_C, btn_L, btn_R, btn_U, btn_D} = mask;
    step(1);
    {btn_C, btn_L, btn_R, btn_U, btn_D} = 5'b0;
  endtask

  int hits[8];
  int n_hits;

  initial begin
    reset = 1'b1; tick = 1'b1; sw_mode = 1'b0; up_down = 1'b0;
    {btn_C, btn_L, btn_R, btn_U, btn_D} = 5'b0;
    U_hold = 1'b0; D_hold = 1'b0;
    #3 reset = 1'b0;
    step(2);
    check_vec("rst_run", run_stop, 0);
    check_vec("rst_cursor", cursor, 0);
    check_vec("rst_blink", blink_on, 1);
    check_vec("rst_edit", w_edit, 0);
    reset = 1'b1;
    step(1);

    // stopwatch
    sw_mode = 1'b1;
    press(5'b00100); check_vec("sw_r1_run", run_stop, 1);
    press(5'b00100); check_vec("sw_r2_stop", run_stop, 0);
    press(5'b01000); check_vec("sw_l_clear", sw_clear, 1);
    step(1);         check_vec("sw_clear_1cyc", sw_clear, 0);
    check_vec("sw_after_clr_run", run_stop, 0);
    press(5'b00100); check_vec("sw_run_again", run_stop, 1);
    press(5'b01000); check_vec("sw_l_in_run_noclr", sw_clear, 0);
    check_vec("sw_l_in_run_still", run_stop, 1);
    press(5'b00100); check_vec("sw_stop_again", run_stop, 0);
    sw_mode = 1'b0;
    press(5'b00100); check_vec("sw_r_gated", run_stop, 0);

    // cursor movement
    press(5'b10000); check_vec("c_enter_edit", w_edit, 1);
    check_vec("c_enter_cur", cursor, 1);
    press(5'b01000); check_vec("l_cur2", cursor, 2);
    press(5'b01000); check_vec("l_cur3", cursor, 3);
    press(5'b01000); check_vec("l_cur4", cursor, 4);
    press(5'b01000); check_vec("l_wrap1", cursor, 1);
    press(5'b00100); check_vec("r_wrap4", cursor, 4);
    press(5'b00010); check_vec("u_inc", w_inc, 1);
    step(1);         check_vec("u_inc_1cyc", w_inc, 0);
    press(5'b00001); check_vec("d_dec", w_dec, 1);
    press(5'b00110); check_vec("r_beats_u_cur", cursor, 3);
    check_vec("r_beats_u_inc", w_inc, 0);
    press(5'b10000); check_vec("c_commit_cur", cursor, 0);
    check_vec("c_commit_edit", w_edit, 0);
    press(5'b00010); check_vec("u_idle_ignored", w_inc, 0);

    // auto-repeat: press and hold U from the same cycle
    press(5'b10000);
    n_hits = 0;
    btn_U = 1'b1; U_hold = 1'b1;
    for (int k = 1; k <= 900; k++) begin
      step(1);
      btn_U = 1'b0;
      if (k == 800) U_hold = 1'b0;
      if (w_inc) begin
        if (n_hits < 8) hits[n_hits] = k;
        n_hits++;
      end
    end
    check_vec("rep_count", n_hits, 5);
    check_vec("rep_press", hits[0], 1);
    check_vec("rep_long", hits[1], 500);
    check_vec("rep_600", hits[2], 600);
    check_vec("rep_700", hits[3], 700);
    check_vec("rep_800", hits[4], 800);
    // both held: no pulses at all
    n_hits = 0;
    U_hold = 1'b1; D_hold = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      step(1);
      if (w_inc || w_dec) n_hits++;
    end
    U_hold = 1'b0; D_hold = 1'b0;
    check_vec("both_held_none", n_hits, 0);
    press(5'b10000); check_vec("rep_exit", w_edit, 0);

    // blink and timeout
    press(5'b10000);
    step(249);  check_vec("blink_249", blink_on, 1);
    step(1);    check_vec("blink_250", blink_on, 0);
    step(250);  check_vec("blink_500", blink_on, 1);
    step(9499); check_vec("to_9999_edit", w_edit, 1);
    step(1);    check_vec("to_10000_edit", w_edit, 0);
    check_vec("to_cursor", cursor, 0);
    check_vec("to_blink", blink_on, 1);
    press(5'b10000);
    step(9998);
    press(5'b00010); check_vec("to_u_inc", w_inc, 1);
    step(9999);      check_vec("to_restart_edit", w_edit, 1);
    step(1);         check_vec("to_restart_idle", w_edit, 0);

    // priority and abort
    press(5'b11000); check_vec("cl_edit", w_edit, 1);
    check_vec("cl_cursor", cursor, 1);
    sw_mode = 1'b1;
    press(5'b00010); check_vec("abort_edit", w_edit, 0);
    check_vec("abort_cursor", cursor, 0);
    check_vec("abort_no_inc", w_inc, 0);

    // direction latch
    up_down = 1'b0;
    press(5'b00100); check_vec("dir_run", run_stop, 1);
    up_down = 1'b1;
    step(3);         check_vec("dir_held_run", sw_mode_o, 0);
    press(5'b00100); check_vec("dir_stop_edge", sw_mode_o, 0);
    step(1);         check_vec("dir_latched", sw_mode_o, 1);

    // reset mid-edit with the stopwatch running in the background
    press(5'b00100);
    sw_mode = 1'b0;
    press(5'b10000);
    press(5'b01000); check_vec("bg_run", run_stop, 1);
    check_vec("pre_rst_cur", cursor, 2);
    reset = 1'b0;
    #1;
    check_vec("mid_rst_run", run_stop, 0);
    check_vec("mid_rst_swmode", sw_mode_o, 0);
    check_vec("mid_rst_edit", w_edit, 0);
    check_vec("mid_rst_cursor", cursor, 0);
    check_vec("mid_rst_blink", blink_on, 1);
    check_vec("mid_rst_incdec", {w_inc, w_dec, sw_clear}, 0);
    step(1);
    reset = 1'b1;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
